// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, state encoding and word helpers for the AES-256 key schedule.
// Macro INV_KSCHED_FWD_EN adds the FWD state used to expand a cipher key forward first.
package aes_pkg;
  localparam int WORD_W = 32;
  localparam int N_RK = 15;
  // Entry 7 is never reached by a valid schedule; it only keeps the 3-bit index total.
  localparam logic [0:7][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
`ifdef INV_KSCHED_FWD_EN
  typedef enum logic [1:0] {IDLE, OUT, FWD} state_e;
`else
  typedef enum logic [1:0] {IDLE, OUT} state_e;
`endif
  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] x);
    return {x[WORD_W-9:0], x[WORD_W-1 -: 8]};
  endfunction
  function automatic logic [WORD_W-1:0] rcon_word(input logic [2:0] i);
    return {RCON[i], 24'h0};
  endfunction
endpackage

// File: rtl/sbox.sv
// sbox: AES forward S-box lookup.
// Ports: a - input byte, c - substituted byte.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);
  localparam logic [0:255][7:0] T = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign c = T[a];
endmodule

// File: rtl/inv_key_schedule.sv
// inv_key_schedule: streams AES-256 round keys 14 down to 0 from the last eight expanded words.
// Ports: clk, rst_n (async, active-low), start/key_in load a key while idle; busy is high
// outside IDLE; rk_valid/rk_ready hand over rk_out with its index rk_idx and rk_last on key 0;
// done pulses once after key 0 is taken.
// Macro INV_KSCHED_FWD_EN adds key_mode: when set at start, key_in is the cipher key and is
// expanded forward for 13 cycles before the round keys are streamed.
module inv_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
`ifdef INV_KSCHED_FWD_EN
  input  logic         key_mode,
`endif
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         done
);
  state_e state_q, state_d;
  logic [0:7][WORD_W-1:0] w_q, w_d;
  logic [3:0] cnt_q, cnt_d, n;
  logic done_q, done_d;
  logic [WORD_W-1:0] inv_x, inv_s, inv_f;
  logic [0:3][WORD_W-1:0] inv_n;
  // Undo one half-step: w[i-8] = w[i] ^ f(w[i-1]); only the first new word needs the S-box.
  assign n = cnt_q - 4'd1;
  assign inv_x = n[0] ? w_q[3] : rot_word(w_q[3]);
  assign inv_f = n[0] ? inv_s : inv_s ^ rcon_word(n[3:1]);
  assign inv_n = {w_q[4] ^ inv_f, w_q[5] ^ w_q[4], w_q[6] ^ w_q[5], w_q[7] ^ w_q[6]};
  for (genvar b = 0; b < 4; b++) begin : g_inv_sb
    sbox u_sb (.a(inv_x[8*b +: 8]), .c(inv_s[8*b +: 8]));
  end
`ifdef INV_KSCHED_FWD_EN
  logic [WORD_W-1:0] fwd_x, fwd_s, fwd_f, m0;
  logic [0:3][WORD_W-1:0] fwd_m;
  // Forward half-step; cnt counts steps 0..12 so its parity picks RotSub+Rcon or plain Sub.
  assign fwd_x = cnt_q[0] ? w_q[7] : rot_word(w_q[7]);
  assign fwd_f = cnt_q[0] ? fwd_s : fwd_s ^ rcon_word(cnt_q[3:1]);
  assign m0 = w_q[0] ^ fwd_f;
  assign fwd_m = {m0, m0 ^ w_q[1], m0 ^ w_q[1] ^ w_q[2], m0 ^ w_q[1] ^ w_q[2] ^ w_q[3]};
  for (genvar b = 0; b < 4; b++) begin : g_fwd_sb
    sbox u_sb (.a(fwd_x[8*b +: 8]), .c(fwd_s[8*b +: 8]));
  end
`endif
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        w_d = key_in;
        cnt_d = 4'(N_RK - 1);
        state_d = OUT;
`ifdef INV_KSCHED_FWD_EN
        if (key_mode) begin
          cnt_d = 4'd0;
          state_d = FWD;
        end
`endif
      end
    end else if (state_q == OUT) begin
      if (rk_ready) begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          done_d = 1'b1;
        end else begin
          cnt_d = n;
          // Key 14 is the upper half of the loaded window, so leaving it needs no new words.
          w_d = cnt_q == 4'(N_RK - 1) ? w_q : {inv_n, w_q[0:3]};
        end
      end
    end
`ifdef INV_KSCHED_FWD_EN
    else begin
      w_d = {w_q[4:7], fwd_m};
      cnt_d = cnt_q == 4'd12 ? 4'(N_RK - 1) : cnt_q + 4'd1;
      state_d = cnt_q == 4'd12 ? OUT : FWD;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign rk_valid = state_q == OUT;
  assign rk_out = cnt_q == 4'(N_RK - 1) ? w_q[4:7] : w_q[0:3];
  assign rk_idx = cnt_q;
  assign rk_last = rk_valid && cnt_q == 4'd0;
  assign done = done_q;
endmodule

// File: tb/tb_inv_key_schedule.sv
// tb_inv_key_schedule: scoreboard bench for inv_key_schedule against a forward key-expansion model.
module tb_inv_key_schedule;
  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;
  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rk_ready = 1'b0;
  logic [255:0] key_in = '0;
  logic busy, rk_valid, rk_last, done;
  logic [127:0] rk_out;
  logic [3:0] rk_idx;
`ifdef INV_KSCHED_FWD_EN
  logic key_mode = 1'b0;
`endif
  int n_pass = 0, n_total = 0, done_cnt = 0;
  exp_t exp_q[$];
  logic [31:0] w [0:59];
  logic [255:0] inv_key;
  logic stall = 1'b0, done_due = 1'b0;
  logic [127:0] prev_out;
  logic [3:0] prev_idx;

  inv_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef INV_KSCHED_FWD_EN
    .key_mode(key_mode),
`endif
    .key_in(key_in), .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_out(rk_out), .rk_idx(rk_idx), .rk_last(rk_last), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction
  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
  endfunction
  task automatic expand(input logic [255:0] k);
    logic [7:0] rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) t = subw(t);
      w[i] = w[i-8] ^ t;
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  // Round keys 14 and 0 of the FIPS-197 key are hand constants; the rest come from the model.
  task automatic push_seq();
    exp_t e;
    for (int r = 14; r >= 0; r--) begin
      e.idx = 4'(r);
      e.key = r == 14 ? 128'h24fc79ccbf0979e9371ac23c6d68de36 :
              r == 0 ? 128'h000102030405060708090a0b0c0d0e0f :
              {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      exp_q.push_back(e);
    end
  endtask
  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask
  task automatic wait_done(input int c0, input string tag);
    for (int i = 0; i < 300 && done_cnt == c0; i++) @(negedge clk);
    chk({tag, "_done_seen"}, done_cnt - c0, 1);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rk_valid"}, rk_valid, 0);
    chk({tag, "_rk_last"}, rk_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rk_out"}, rk_out, 0);
    chk({tag, "_rk_idx"}, rk_idx, 0);
  endtask
  task automatic wait_idx(input logic [3:0] idx, input string tag);
    for (int i = 0; i < 100 && !(rk_valid && rk_idx == idx); i++) begin
      @(posedge clk); #1;
    end
    chk(tag, {rk_valid, rk_idx}, {1'b1, idx});
  endtask

  // Monitor: pops the scoreboard on each transfer, checks stall stability and the done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall = 1'b0;
      done_due = 1'b0;
    end else begin
      if (done || done_due) chk("done_pulse", done, done_due);
      if (done) done_cnt++;
      done_due = 1'b0;
      if (stall) begin
        chk("stall_valid", rk_valid, 1);
        chk("stall_rk_out", rk_out, prev_out);
        chk("stall_rk_idx", rk_idx, prev_idx);
      end
      if (rk_valid && rk_ready) begin
        if (exp_q.size() == 0) chk("unexpected_key", rk_idx, 4'hf);
        else begin
          e = exp_q.pop_front();
          chk("rk_idx", rk_idx, e.idx);
          chk("rk_out", rk_out, e.key);
          chk("rk_last", rk_last, e.idx == 4'd0);
          done_due = rk_last;
        end
      end
      stall = rk_valid && !rk_ready;
      prev_out = rk_out;
      prev_idx = rk_idx;
    end
  end

  initial begin
    int c0;
    expand(FIPS_KEY);
    inv_key = {w[52], w[53], w[54], w[55], w[56], w[57], w[58], w[59]};
    #12 chk_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    key_in = inv_key;
    rk_ready = 1'b1;
    c0 = done_cnt;
    push_seq();
    start_pulse();
    wait_done(c0, "streaming");
    rk_ready = 1'b0;
    c0 = done_cnt;
    push_seq();
    start_pulse();
    for (int i = 0; i < 600 && done_cnt == c0; i++) begin
      @(posedge clk); #1 rk_ready = 1'($urandom_range(0, 1));
    end
    rk_ready = 1'b1;
    wait_done(c0, "stalls");
    c0 = done_cnt;
    push_seq();
    start_pulse();
    wait_idx(4'd7, "reach_idx7");
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idx(4'd0, "reach_idx0");
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(c0, "start_ignored");
    repeat (3) @(negedge clk);
    chk("no_reload_busy", busy, 0);
    chk("no_reload_valid", rk_valid, 0);
    push_seq();
    start_pulse();
    wait_idx(4'd5, "reach_idx5");
    rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_resume_busy", busy, 0);
    c0 = done_cnt;
    push_seq();
    start_pulse();
    wait_done(c0, "replay");
`ifdef INV_KSCHED_FWD_EN
    begin
      int quiet = 0;
      key_mode = 1'b1;
      key_in = FIPS_KEY;
      c0 = done_cnt;
      push_seq();
      start_pulse();
      key_mode = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (rk_valid) break;
        if (busy) quiet++;
      end
      chk("fwd_quiet_cycles", quiet, 13);
      wait_done(c0, "fwd");
    end
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
